// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, hold, flush and bubble counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_regdst_i,
    input  logic              id_branch_i,
    input  logic              id_memtoreg_i,
    input  logic              id_memwrite_i,
    input  logic              id_alusrc_i,
    input  logic              id_regwrite_i,
    input  logic              id_jump_i,
    input  logic [3:0]        id_aluop_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    output logic              ex_valid_o,
    output logic              ex_regdst_o,
    output logic              ex_branch_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_regwrite_o,
    output logic              ex_jump_o,
    output logic [3:0]        ex_aluop_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic flush_pend;
    logic rt_used;
    logic load_use;
    logic kill;

    // rt is only a source for R-type, branch compare and store data
    always_comb begin
        rt_used  = id_regdst_i | id_branch_i | id_memwrite_i;
        load_use = ex_valid_o & ex_memtoreg_o & ex_regwrite_o & (ex_rt_o != '0) & id_valid_i
                 & ((ex_rt_o == id_rs_i) | (rt_used & (ex_rt_o == id_rt_i)));
        kill     = flush_i | flush_pend;
    end

    assign stall_o = load_use | hold_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_regdst_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_alusrc_o   <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_aluop_o    <= '0;
            ex_pc4_o      <= '0;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs_o       <= '0;
            ex_rt_o       <= '0;
            ex_rd_o       <= '0;
            flush_pend    <= 1'b0;
            bubble_cnt_o  <= '0;
        end else if (hold_i) begin
            // a flush seen while frozen must still kill the instruction once hold releases
            if (flush_i) flush_pend <= 1'b1;
        end else if (kill | load_use) begin
            ex_valid_o    <= 1'b0;
            ex_regdst_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_alusrc_o   <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_jump_o     <= 1'b0;
            ex_aluop_o    <= '0;
            ex_pc4_o      <= '0;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs_o       <= '0;
            ex_rt_o       <= '0;
            ex_rd_o       <= '0;
            flush_pend    <= 1'b0;
            if (!kill && (bubble_cnt_o != '1)) bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end else begin
            ex_valid_o    <= id_valid_i;
            ex_regdst_o   <= id_regdst_i;
            ex_branch_o   <= id_branch_i;
            ex_memtoreg_o <= id_memtoreg_i;
            ex_memwrite_o <= id_memwrite_i;
            ex_alusrc_o   <= id_alusrc_i;
            ex_regwrite_o <= id_regwrite_i;
            ex_jump_o     <= id_jump_i;
            ex_aluop_o    <= id_aluop_i;
            ex_pc4_o      <= id_pc4_i;
            ex_rs_data_o  <= id_rs_data_i;
            ex_rt_data_o  <= id_rt_data_i;
            ex_imm_o      <= id_imm_i;
            ex_rs_o       <= id_rs_i;
            ex_rt_o       <= id_rt_i;
            ex_rd_o       <= id_rd_i;
        end
    end

endmodule
